// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
// The request struct fixes the address/data widths used on the memory side.
package mem_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 512;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT
  } t_arb_state;

  typedef struct packed {
    logic                  is_wr;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
  } t_mem_req;

  // Watchdog counter width; it counts 0 .. timeout-1.
  function automatic int unsigned f_wd_width(input int unsigned timeout);
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IW'((32'(i_ptr) + k) % N);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multiplexes NUM_CH clients onto one memory request port: round-robin,
// single outstanding transaction, completion watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ADDR_W  = ARB_ADDR_W,
  parameter int unsigned DATA_W  = ARB_DATA_W,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        cl_rd_req,
  input  logic [NUM_CH-1:0]        cl_wr_req,
  input  logic [NUM_CH*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CH*DATA_W-1:0] cl_wr_data,
  output logic [NUM_CH-1:0]        cl_grant,
  output logic [NUM_CH-1:0]        cl_rd_valid,
  output logic [NUM_CH-1:0]        cl_wr_done,
  output logic [NUM_CH-1:0]        cl_err,
  output logic [DATA_W-1:0]        cl_rd_data,
  input  logic                     mem_buffer_addr_valid,
  input  logic                     mem_data_valid,
  input  logic                     mem_write_done,
  input  logic [DATA_W-1:0]        mem_rd_data,
  output logic                     mem_rd_req,
  output logic                     mem_wr_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wr_data
);

  localparam int unsigned       IW      = $clog2(NUM_CH);
  localparam int unsigned       WD_W    = f_wd_width(TIMEOUT);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [IW-1:0]     LAST_CH = IW'(NUM_CH - 1);

  t_arb_state          r_state, w_state_nxt;
  logic [IW-1:0]       r_ptr, w_ptr_nxt;
  logic [IW-1:0]       r_owner, w_owner_nxt;
  logic [WD_W-1:0]     r_wd, w_wd_nxt;
  t_mem_req            r_req, w_req_nxt;
  logic                r_issue, w_issue_nxt;
  logic [NUM_CH-1:0]   r_grant, w_grant_nxt;
  logic [NUM_CH-1:0]   r_rd_valid, w_rd_valid_nxt;
  logic [NUM_CH-1:0]   r_wr_done, w_wr_done_nxt;
  logic [NUM_CH-1:0]   r_err, w_err_nxt;
  logic [DATA_W-1:0]   r_rd_data, w_rd_data_nxt;

  logic [NUM_CH-1:0]   w_arb_grant;
  logic [IW-1:0]       w_arb_idx;
  logic                w_arb_any;
  logic                w_win_rd;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_data;

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .i_req   (cl_rd_req | cl_wr_req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  // Read wins when a channel raises both; its write stays pending.
  always_comb begin
    w_win_rd   = |(w_arb_grant & cl_rd_req);
    w_win_addr = '0;
    w_win_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (w_arb_grant[k]) begin
        w_win_addr = cl_addr[k*ADDR_W +: ADDR_W];
        w_win_data = cl_wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_wd_nxt       = r_wd;
    w_req_nxt      = r_req;
    w_rd_data_nxt  = r_rd_data;
    w_issue_nxt    = 1'b0;
    w_grant_nxt    = '0;
    w_rd_valid_nxt = '0;
    w_wr_done_nxt  = '0;
    w_err_nxt      = '0;
    unique case (r_state)
      IDLE: begin
        if (mem_buffer_addr_valid && w_arb_any) begin
          w_issue_nxt     = 1'b1;
          w_grant_nxt     = w_arb_grant;
          w_owner_nxt     = w_arb_idx;
          w_ptr_nxt       = (w_arb_idx == LAST_CH) ? '0 : w_arb_idx + 1'b1;
          w_wd_nxt        = '0;
          w_req_nxt.is_wr = !w_win_rd;
          w_req_nxt.addr  = w_win_addr;
          w_req_nxt.data  = w_win_data;
          w_state_nxt     = w_win_rd ? RD_WAIT : WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_data_valid) begin
          w_rd_valid_nxt[r_owner] = 1'b1;
          w_rd_data_nxt           = mem_rd_data;
          w_state_nxt             = IDLE;
        end else if (r_wd == WD_LAST) begin
          w_err_nxt[r_owner] = 1'b1;
          w_state_nxt        = IDLE;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      WR_WAIT: begin
        if (mem_write_done) begin
          w_wr_done_nxt[r_owner] = 1'b1;
          w_state_nxt            = IDLE;
        end else if (r_wd == WD_LAST) begin
          w_err_nxt[r_owner] = 1'b1;
          w_state_nxt        = IDLE;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_wd       <= '0;
      r_req      <= '0;
      r_issue    <= 1'b0;
      r_grant    <= '0;
      r_rd_valid <= '0;
      r_wr_done  <= '0;
      r_err      <= '0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_wd       <= w_wd_nxt;
      r_req      <= w_req_nxt;
      r_issue    <= w_issue_nxt;
      r_grant    <= w_grant_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_wr_done  <= w_wr_done_nxt;
      r_err      <= w_err_nxt;
      r_rd_data  <= w_rd_data_nxt;
    end
  end

  assign cl_grant    = r_grant;
  assign cl_rd_valid = r_rd_valid;
  assign cl_wr_done  = r_wr_done;
  assign cl_err      = r_err;
  assign cl_rd_data  = r_rd_data;
  assign mem_rd_req  = r_issue & ~r_req.is_wr;
  assign mem_wr_req  = r_issue & r_req.is_wr;
  assign mem_addr    = r_req.addr;
  assign mem_wr_data = r_req.data;

endmodule
